pipe_controller: RTL and testbench

- Control and hazard sequencer for the 5-stage ARM-subset pipelined datapath.
- Decodes InstrD and carries control through E/M/W pipeline registers.
- Evaluates condition codes against a registered flags register.
- Generates forwarding selects and stall/flush signals from the datapath's register-match outputs.
- Sits beside the datapath at top level; drives every datapath control input.

---
 rtl/pipe_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_pipe_controller.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_controller.sv
// Control and hazard sequencer for a 5-stage ARM-subset pipeline (decode, E/M/W control, cond flags, forwarding).
// Latency: decode, forwarding and hazard outputs are combinational; control reaches E/M/W after 1/2/3 clocks.
// Backpressure: StallF/StallD hold fetch/decode on load-use and pending PC writes; E takes a bubble via FlushE.
module pipe_controller #(
    parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [3:0]  ALUFlagsE,
    input  logic        Match_1E_M,
    input  logic        Match_1E_W,
    input  logic        Match_2E_M,
    input  logic        Match_2E_W,
    input  logic        Match_12D_E,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [2:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        MemWriteM,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic        RegWriteW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;

    typedef struct packed {
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       branch;
        logic       pc_src;
        logic [1:0] flag_w;
        logic       alu_src;
        logic [2:0] alu_ctl;
        logic [3:0] cond;
    } ctl_t;

    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       dp_valid;
    ctl_t       ctl_d;
    ctl_t       ctl_e;
    ctl_t       ctl_e_next;
    logic [3:0] flags_q;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
    logic       cond_ex_e;
    logic       branch_taken_e;
    logic       ld_stall_d;
    logic       flush_e;
    logic       pc_wr_pending_f;
    logic       reg_write_m;
    logic       mem_write_m;
    logic       mem_to_reg_m;
    logic       pc_src_m;
    logic       reg_write_w;
    logic       mem_to_reg_w;
    logic       pc_src_w;
    logic       unused_instr;

    assign op    = InstrD[27:26];
    assign funct = InstrD[25:20];
    assign rd    = InstrD[15:12];

    // Register-number and immediate fields belong to the datapath only.
    assign unused_instr = ^{InstrD[19:16], InstrD[11:0]};

    always_comb begin
        ctl_d      = '0;
        ctl_d.cond = InstrD[31:28];
        RegSrcD    = 2'b00;
        ImmSrcD    = 2'b00;
        dp_valid   = 1'b0;
        case (op)
            2'b00: begin
                ctl_d.alu_src = funct[5];
                dp_valid      = 1'b1;
                case (funct[4:1])
                    4'b0100: begin ctl_d.alu_ctl = ALU_ADD; ctl_d.reg_w = 1'b1; end
                    4'b0010: begin ctl_d.alu_ctl = ALU_SUB; ctl_d.reg_w = 1'b1; end
                    4'b0000: begin ctl_d.alu_ctl = ALU_AND; ctl_d.reg_w = 1'b1; end
                    4'b1100: begin ctl_d.alu_ctl = ALU_ORR; ctl_d.reg_w = 1'b1; end
                    4'b1010: ctl_d.alu_ctl = ALU_SUB;
                    default: dp_valid = 1'b0;
                endcase
                ctl_d.flag_w[1] = dp_valid & funct[0];
                // C and V are only meaningful for the arithmetic ops (CMP included).
                ctl_d.flag_w[0] = dp_valid & funct[0] &
                                  ((ctl_d.alu_ctl == ALU_ADD) || (ctl_d.alu_ctl == ALU_SUB));
            end
            2'b01: begin
                RegSrcD       = 2'b10;
                ImmSrcD       = 2'b01;
                ctl_d.alu_src = 1'b1;
                ctl_d.alu_ctl = ALU_ADD;
                if (funct[0]) begin
                    ctl_d.reg_w      = 1'b1;
                    ctl_d.mem_to_reg = 1'b1;
                end else begin
                    ctl_d.mem_w = 1'b1;
                end
            end
            2'b10: begin
                RegSrcD       = 2'b01;
                ImmSrcD       = 2'b10;
                ctl_d.alu_src = 1'b1;
                ctl_d.alu_ctl = ALU_ADD;
                ctl_d.branch  = 1'b1;
            end
            default: ;
        endcase
        ctl_d.pc_src = ctl_d.reg_w & (rd == 4'hF);
    end

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_ex_e = 1'b0;
        case (ctl_e.cond)
            4'b0000: cond_ex_e = flag_z;
            4'b0001: cond_ex_e = ~flag_z;
            4'b0010: cond_ex_e = flag_c;
            4'b0011: cond_ex_e = ~flag_c;
            4'b0100: cond_ex_e = flag_n;
            4'b0101: cond_ex_e = ~flag_n;
            4'b0110: cond_ex_e = flag_v;
            4'b0111: cond_ex_e = ~flag_v;
            4'b1000: cond_ex_e = flag_c & ~flag_z;
            4'b1001: cond_ex_e = ~flag_c | flag_z;
            4'b1010: cond_ex_e = (flag_n == flag_v);
            4'b1011: cond_ex_e = (flag_n != flag_v);
            4'b1100: cond_ex_e = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex_e = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex_e = 1'b1;
            default: cond_ex_e = 1'b0;
        endcase
    end

    assign branch_taken_e  = ctl_e.branch & cond_ex_e;
    assign ld_stall_d      = Match_12D_E & ctl_e.mem_to_reg & ctl_e.reg_w;
    assign flush_e         = ld_stall_d | branch_taken_e;
    assign pc_wr_pending_f = ctl_d.pc_src | ctl_e.pc_src | pc_src_m;

    // A flushed E stage keeps its datapath selects but loses every enable.
    always_comb begin
        ctl_e_next = ctl_d;
        if (flush_e) begin
            ctl_e_next.reg_w      = 1'b0;
            ctl_e_next.mem_w      = 1'b0;
            ctl_e_next.mem_to_reg = 1'b0;
            ctl_e_next.branch     = 1'b0;
            ctl_e_next.pc_src     = 1'b0;
            ctl_e_next.flag_w     = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctl_e <= '0;
        end else begin
            ctl_e <= ctl_e_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= FLAGS_RESET;
        end else begin
            if (ctl_e.flag_w[1] && cond_ex_e) flags_q[3:2] <= ALUFlagsE[3:2];
            if (ctl_e.flag_w[0] && cond_ex_e) flags_q[1:0] <= ALUFlagsE[1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            pc_src_m     <= 1'b0;
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            pc_src_w     <= 1'b0;
        end else begin
            reg_write_m  <= ctl_e.reg_w & cond_ex_e;
            mem_write_m  <= ctl_e.mem_w & cond_ex_e;
            mem_to_reg_m <= ctl_e.mem_to_reg;
            pc_src_m     <= ctl_e.pc_src & cond_ex_e;
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
            pc_src_w     <= pc_src_m;
        end
    end

    // The younger producer in M wins over W.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (Match_1E_M && reg_write_m)      ForwardAE = 2'b10;
        else if (Match_1E_W && reg_write_w) ForwardAE = 2'b01;
        if (Match_2E_M && reg_write_m)      ForwardBE = 2'b10;
        else if (Match_2E_W && reg_write_w) ForwardBE = 2'b01;
    end

    assign ALUSrcE      = ctl_e.alu_src;
    assign ALUControlE  = ctl_e.alu_ctl;
    assign BranchTakenE = branch_taken_e;
    assign MemWriteM    = mem_write_m;
    assign MemtoRegW    = mem_to_reg_w;
    assign PCSrcW       = pc_src_w;
    assign RegWriteW    = reg_write_w;
    assign StallF       = ld_stall_d | pc_wr_pending_f;
    assign StallD       = ld_stall_d;
    assign FlushD       = pc_wr_pending_f | pc_src_w | branch_taken_e;

endmodule

// File: tb/tb_pipe_controller.sv
// Bench for pipe_controller: directed program fragments plus random instruction streams,
// scored against an instruction-record pipeline model through an expectation queue.
module tb_pipe_controller;

    localparam logic [3:0]  FLAGS_RST = 4'b0100;
    localparam logic [31:0] NOP       = 32'hE1A00000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD;
    logic [3:0]  ALUFlagsE;
    logic        Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic [1:0]  RegSrcD, ImmSrcD, ForwardAE, ForwardBE;
    logic        ALUSrcE, BranchTakenE, MemWriteM, MemtoRegW, PCSrcW, RegWriteW;
    logic [2:0]  ALUControlE;
    logic        StallF, StallD, FlushD;

    always #5 clk = ~clk;

    pipe_controller #(.FLAGS_RESET(FLAGS_RST)) dut (
        .clk(clk), .reset(reset), .InstrD(InstrD), .ALUFlagsE(ALUFlagsE),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
        .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .BranchTakenE(BranchTakenE), .MemWriteM(MemWriteM), .MemtoRegW(MemtoRegW),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD)
    );

    // One in-flight instruction as the model sees it.
    typedef struct packed {
        logic       rw, mw, m2r, br, pcs;
        logic [1:0] fw;
        logic       asrc;
        logic [2:0] aluc;
        logic [3:0] cond;
    } rec_t;

    // match = {1E_M, 1E_W, 2E_M, 2E_W, 12D_E}
    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  match;
        logic [3:0]  aflags;
    } stim_t;

    typedef logic [19:0] obs_t;

    rec_t       st_e, st_m, st_w, cur_d;
    logic [3:0] mflags, cur_af;
    logic       cur_cx, cur_bt, cur_ld, cur_stalld;
    obs_t       sb_q[$];
    obs_t       exp_v, act_v;
    stim_t      held;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    function automatic stim_t mk(input logic [31:0] ins, input logic [4:0] m, input logic [3:0] f);
        stim_t s;
        s.instr = ins; s.match = m; s.aflags = f;
        return s;
    endfunction

    // ARM condition table: even codes pick a base predicate, odd codes invert it.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cc, v, base;
        {n, z, cc, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cc;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cc && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    function automatic rec_t decode(input logic [31:0] ins);
        rec_t r;
        logic [5:0] fn;
        logic known;
        r = '0; fn = ins[25:20]; r.cond = ins[31:28]; known = 1'b1;
        case (ins[27:26])
            2'd0: begin
                r.asrc = fn[5];
                case (fn[4:1])
                    4'b0100: r.aluc = 3'd0;
                    4'b0010: r.aluc = 3'd1;
                    4'b0000: r.aluc = 3'd2;
                    4'b1100: r.aluc = 3'd3;
                    4'b1010: r.aluc = 3'd1;
                    default: known = 1'b0;
                endcase
                r.rw = known && (fn[4:1] != 4'b1010);
                r.fw = (known && fn[0]) ? {1'b1, r.aluc < 3'd2} : 2'b00;
            end
            2'd1: begin
                r.asrc = 1'b1;
                if (fn[0]) begin r.rw = 1'b1; r.m2r = 1'b1; end
                else r.mw = 1'b1;
            end
            2'd2: begin r.asrc = 1'b1; r.br = 1'b1; end
            default: ;
        endcase
        r.pcs = r.rw && (ins[15:12] == 4'hF);
        return r;
    endfunction

    task automatic model_reset();
        st_e = '0; st_m = '0; st_w = '0; mflags = FLAGS_RST;
    endtask

    task automatic model_advance();
        if (cur_cx && st_e.fw[1]) mflags[3:2] = cur_af[3:2];
        if (cur_cx && st_e.fw[0]) mflags[1:0] = cur_af[1:0];
        st_w = st_m;
        st_m = st_e;
        st_m.rw  = st_m.rw & cur_cx;
        st_m.mw  = st_m.mw & cur_cx;
        st_m.pcs = st_m.pcs & cur_cx;
        st_e = cur_d;
        if (cur_ld || cur_bt) begin
            st_e.rw = 1'b0; st_e.mw = 1'b0; st_e.m2r = 1'b0;
            st_e.br = 1'b0; st_e.pcs = 1'b0; st_e.fw = 2'b00;
        end
    endtask

    task automatic model_eval(input stim_t s);
        logic [1:0] op, regsrc, immsrc, fa, fb;
        logic pend;
        op     = s.instr[27:26];
        cur_d  = decode(s.instr);
        cur_cx = cond_ok(st_e.cond, mflags);
        cur_bt = st_e.br & cur_cx;
        cur_ld = s.match[0] & st_e.m2r & st_e.rw;
        cur_af = s.aflags;
        cur_stalld = cur_ld;
        regsrc = (op == 2'd1) ? 2'd2 : (op == 2'd2) ? 2'd1 : 2'd0;
        immsrc = (op == 2'd3) ? 2'd0 : op;
        fa = (s.match[4] && st_m.rw) ? 2'd2 : (s.match[3] && st_w.rw) ? 2'd1 : 2'd0;
        fb = (s.match[2] && st_m.rw) ? 2'd2 : (s.match[1] && st_w.rw) ? 2'd1 : 2'd0;
        pend = cur_d.pcs | st_e.pcs | st_m.pcs;
        sb_q.push_back({regsrc, immsrc, st_e.asrc, st_e.aluc, cur_bt, st_m.mw, st_w.m2r,
                        st_w.pcs, st_w.rw, fa, fb, cur_ld | pend, cur_ld, pend | st_w.pcs | cur_bt});
    endtask

    // Inputs change 1 time unit after the rising edge; reset is applied there too.
    task automatic tick(input stim_t s, input logic rst_lvl);
        @(posedge clk);
        if (reset) model_advance();
        #1;
        reset = rst_lvl;
        if (!rst_lvl) model_reset();
        InstrD = s.instr;
        {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = s.match;
        ALUFlagsE = s.aflags;
        model_eval(s);
    endtask

    // Holds the decode instruction while the model predicts a decode stall.
    task automatic issue(input stim_t s);
        int guard = 0;
        while (cur_stalld && guard < 8) begin
            tick(held, 1'b1);
            guard++;
        end
        held = s;
        tick(s, 1'b1);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(mk(NOP, 5'b0, 4'b0));
    endtask

    function automatic stim_t rand_stim();
        logic [31:0] ins;
        logic [3:0] cmd;
        ins = $urandom;
        if ($urandom_range(0, 9) < 7) ins[31:28] = 4'hE;
        cmd = ins[24:21];
        case ($urandom_range(0, 5))
            0: cmd = 4'b0100;
            1: cmd = 4'b0010;
            2: cmd = 4'b0000;
            3: cmd = 4'b1100;
            4: cmd = 4'b1010;
            default: ;
        endcase
        if (ins[27:26] == 2'b00) ins[24:21] = cmd;
        if ($urandom_range(0, 5) == 0) ins[15:12] = 4'hF;
        return mk(ins, 5'($urandom), 4'($urandom));
    endfunction

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_v = sb_q.pop_front();
            act_v = {RegSrcD, ImmSrcD, ALUSrcE, ALUControlE, BranchTakenE, MemWriteM, MemtoRegW,
                     PCSrcW, RegWriteW, ForwardAE, ForwardBE, StallF, StallD, FlushD};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL cycle %0d outputs got=%05h want=%05h (RegSrc,ImmSrc,ALUSrc,ALUCtl,BrTaken,MemWM,MemtoRegW,PCSrcW,RegWW,FwdA,FwdB,StallF,StallD,FlushD)",
                         cyc, act_v, exp_v);
            end
            cyc++;
        end
    end

    initial begin
        reset = 1'b0; InstrD = NOP; ALUFlagsE = 4'b0;
        {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = 5'b0;
        model_reset();
        cur_stalld = 1'b0;
        held = mk(NOP, 5'b0, 4'b0);
        tick(held, 1'b0);
        tick(held, 1'b0);

        // ALU forwarding from M, then from W
        issue(mk(32'hE0821003, 5'b00000, 4'b0));
        issue(mk(32'hE0414005, 5'b00000, 4'b0));
        issue(mk(32'hE0846001, 5'b11000, 4'b0));
        issue(mk(NOP,          5'b01000, 4'b0));
        nops(2);

        // load-use stall, bubble in M, forwarding from W
        issue(mk(32'hE5921000, 5'b00000, 4'b0));
        issue(mk(32'hE0813001, 5'b00001, 4'b0));
        issue(mk(NOP,          5'b11110, 4'b0));
        nops(3);

        // condition codes: EQ taken, NE not taken (including a store)
        issue(mk(32'hE1510001, 5'b0, 4'b0000));
        issue(mk(32'h02822001, 5'b0, 4'b0100));
        nops(4);
        issue(mk(32'hE1510001, 5'b0, 4'b0000));
        issue(mk(32'h12822001, 5'b0, 4'b0100));
        issue(mk(32'h15821000, 5'b0, 4'b0000));
        nops(4);

        // unconditional branch, then BEQ with Z clear
        issue(mk(32'hEA000000, 5'b0, 4'b0));
        nops(2);
        issue(mk(32'hE1510001, 5'b0, 4'b0000));
        issue(mk(32'h0A000000, 5'b0, 4'b0000));
        nops(3);

        // write to PC through the ALU
        issue(mk(32'hE280F000, 5'b0, 4'b0));
        nops(5);

        // reset during a load-use stall, then EQ runs on the reset flags
        issue(mk(32'hE5921000, 5'b00000, 4'b0));
        issue(mk(32'hE0813001, 5'b00001, 4'b0));
        tick(held, 1'b0);
        tick(mk(NOP, 5'b0, 4'b0), 1'b0);
        nops(3);
        issue(mk(32'h02822001, 5'b0, 4'b0));
        nops(3);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                tick(rand_stim(), 1'b0);
                tick(rand_stim(), 1'b0);
            end
            issue(rand_stim());
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue got=%0d want=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
